// File: rtl/fetch_sequencer_pkg.sv
// Shared types, constants and address helpers for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    typedef logic        clock_t;
    typedef logic        bool_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] addr_reg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam addr_t       INSTR_STEP  = 32'd4;

    function automatic addr_t next_pc(input addr_t a);
        return a + INSTR_STEP;
    endfunction

    function automatic bool_t is_misaligned(input addr_t a);
        return (a[1:0] != 2'b00);
    endfunction

    // With trapping enabled a misaligned target diverts to the trap vector,
    // otherwise the low bits are simply dropped.
    function automatic addr_t redirect_pc(input addr_t tgt, input addr_t trap, input bool_t trap_en);
        addr_t r;
        if (trap_en && is_misaligned(tgt)) begin
            r = trap;
        end else begin
            r = tgt & 32'hFFFF_FFFC;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_sequencer_output_reg.sv
// Holding register for the fetched instruction presented to decode; clear beats load.
module fetch_output_reg
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [31:0] next_addr
);

    // Capture a fetched word with its PC and link address, or empty the slot
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            valid     <= 1'b0;
            addr      <= 32'h0000_0000;
            data      <= 32'h0000_0000;
            next_addr <= INSTR_STEP;
        end else if (load) begin
            valid     <= 1'b1;
            addr      <= load_addr;
            data      <= load_data;
            next_addr <= next_pc(load_addr);
        end else begin
            valid     <= valid;
            addr      <= addr;
            data      <= data;
            next_addr <= next_addr;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect/squash handling.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirects trap and pulse misalign_fault).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] instr_next_addr,
    input  logic        instr_ready,
    output logic        misalign_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bool_t TRAP_EN = 1'b1;
`else
    localparam bool_t TRAP_EN = 1'b0;
`endif

    fetch_state_t state_r;
    addr_reg_t    pc_r;
    logic         squash_r;
    logic         req_valid_r;
    addr_t        tgt_s;
    logic         req_hs_s;
    logic         out_load_s;
    logic         out_clear_s;

    assign tgt_s          = redirect_pc(redirect_target, TRAP_VECTOR, TRAP_EN);
    assign req_hs_s       = req_valid_r & imem_req_ready;
    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;

    // Output register: a redirect or consume empties it, a live response fills it
    always_comb begin
        out_load_s  = 1'b0;
        out_clear_s = 1'b0;
        if (redirect_valid) begin
            out_clear_s = 1'b1;
        end else if ((state_r == ST_HOLD) && instr_ready) begin
            out_clear_s = 1'b1;
        end else if ((state_r == ST_WAIT) && imem_resp_valid && !squash_r) begin
            out_load_s = 1'b1;
        end else begin
            out_load_s  = 1'b0;
            out_clear_s = 1'b0;
        end
    end

    // Fetch FSM: one request outstanding at most; redirect always rewrites pc last
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_VECTOR;
            squash_r    <= 1'b0;
            req_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
                ST_REQ: begin
                    if (req_hs_s) begin
                        state_r     <= ST_WAIT;
                        req_valid_r <= 1'b0;
                        squash_r    <= redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        squash_r <= 1'b0;
                        if (squash_r || redirect_valid) begin
                            state_r     <= ST_REQ;
                            req_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_HOLD;
                            pc_r    <= next_pc(pc_r);
                        end
                    end else if (redirect_valid) begin
                        squash_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready || redirect_valid) begin
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    squash_r    <= 1'b0;
                    req_valid_r <= 1'b0;
                end
            endcase
            if (redirect_valid) begin
                pc_r <= tgt_s;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_r;

    // One-cycle pulse following a misaligned redirect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= redirect_valid & is_misaligned(redirect_target);
        end
    end

    assign misalign_fault = fault_r;
`else
    assign misalign_fault = 1'b0;
`endif

    fetch_output_reg u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (out_load_s),
        .clear     (out_clear_s),
        .load_addr (pc_r),
        .load_data (imem_resp_data),
        .valid     (instr_valid),
        .addr      (instr_addr),
        .data      (instr_data),
        .next_addr (instr_next_addr)
    );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the RISC-V core: owns the architectural program counter, issues one request at a time to instruction memory over a valid/ready handshake, and hands fetched words to decode over a second valid/ready handshake. Applies control-flow redirects (branch/jump/trap) from execute, squashing any in-flight fetch. Sits between the PC-update logic and the instruction-memory port, replacing a free-running per-clock PC increment.

## Interface
- RESET_VECTOR, 'h0, PC value loaded on reset
- TRAP_VECTOR, 'h4, misaligned-redirect target (only with FETCH_MISALIGN_TRAP_EN)
- clk  in  1  Clock
- reset_n  in  1  Reset; synchronous and active-low
- redirect_valid  in  1  Bool; take redirect_target as next fetch address
- redirect_target  in  32  Addr; redirect destination
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  request address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response word present (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_resp_data  in  32  instruction word
- instr_valid  out  1  fetched instruction available to decode
- instr_addr  out  32  PC of instr_data
- instr_data  out  32  instruction word
- instr_next_addr  out  32  instr_addr + 4 (link value)
- instr_ready  in  1  decode consumes instruction
- misalign_fault  out  1  one-cycle pulse on misaligned redirect (macro only)

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: only after reset; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. Handshake (valid&ready) -> WAIT.
- WAIT: on imem_resp_valid: if squash flag set, discard word, clear flag, -> REQ; else latch word and pc into output register, pc <= pc+4, -> HOLD.
- HOLD: instr_valid=1. On instr_ready: if next request can be issued -> REQ, output cleared same edge.
- Redirect (any state): pc <= target; instr_valid dropped next cycle (held instruction discarded); in WAIT sets squash flag (response still awaited then dropped); in REQ an already-accepted request in the same cycle counts as in WAIT.
- Redirect and instr_ready same cycle: redirect wins; held instruction counts as consumed.
- Redirect and imem_resp_valid same cycle in WAIT: response dropped, -> REQ at target; squash flag not set.
- Back-to-back redirects: last one wins; at most one squash pending.
- PC arithmetic: 32-bit, pc+4 wraps 'hFFFF_FFFC -> 'h0 with no flag.
- imem_req_addr and pc stay stable while imem_req_valid=1 and not ready, unless a redirect occurs.

## Timing
- Reset (reset_n=0 at edge): state IDLE, pc=RESET_VECTOR, squash=0, imem_req_valid=0, instr_valid=0, instr_addr=0, instr_data=0, misalign_fault=0. Reset mid-WAIT: the outstanding response arriving after reset is ignored (squash=1 out of reset is not used; memory is reset alongside).
- First request: second cycle after reset_n rises.
- Latency: request accepted cycle N, response cycle N+k -> instr_valid at N+k+1.
- Throughput: one instruction per (k+2) cycles minimum; no overlap.
- Redirect in cycle N -> imem_req_addr=target at N+1 (if not waiting on a response).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect_target[1:0]≠0 -> pc <= TRAP_VECTOR, misalign_fault=1 next cycle for one cycle.
- Undefined: redirect_target[1:0] forced to 0; misalign_fault tied 0.

## Structure
- Shared package: Clock, Bool, Addr, AddrReg typedefs, fetch state enum, INSTR_BYTES=4.
- One sub-module: fetch_output_reg (instr_addr/data/valid holding register with clear).

## Test plan
- Reset with RESET_VECTOR='h100, memory ready=1, k=1 -> requests 'h100,'h104,'h108; instr_valid every 3 cycles with matching data.
- instr_ready=0 for 5 cycles -> HOLD, instr_data stable, no new request issued.
- Redirect to 'h200 while WAIT for 'h104 -> 'h104 response dropped, next instr_addr='h200.
- Redirect same cycle as imem_resp_valid -> word dropped, request 'h200 next cycle.
- pc='hFFFF_FFFC -> next request 'h0.
- Redirect to 'h202: macro on -> pc=TRAP_VECTOR, one-cycle misalign_fault; macro off -> request 'h200.
